// File: rtl/vga_capture.sv
// VGA sink: registers the incoming sync/RGB stream, locks to line and frame timing,
// flags timing violations and emits per-pixel x/y coordinates with a valid strobe.
module vga_capture #(
   parameter int unsigned HPIXELS    = 800,
   parameter int unsigned VLINES     = 521,
   parameter int unsigned HACT_START = 145,
   parameter int unsigned HACT       = 640,
   parameter int unsigned VACT_START = 31,
   parameter int unsigned VACT       = 480
) (
   input  logic       dclk,
   input  logic       clr,
   input  logic       hsync,
   input  logic       vsync,
   input  logic [3:0] red_i,
   input  logic [3:0] green_i,
   input  logic [3:0] blue_i,
   output logic       px_valid,
   output logic [9:0] x,
   output logic [9:0] y,
   output logic [3:0] red_o,
   output logic [3:0] green_o,
   output logic [3:0] blue_o,
   output logic       frame_start,
   output logic       locked,
   output logic       sync_err
);

   localparam logic [9:0] C_HLAST = 10'(HPIXELS - 1);
   localparam logic [9:0] C_HLEN  = 10'(HPIXELS);
   localparam logic [9:0] C_VLAST = 10'(VLINES - 1);
   localparam logic [9:0] C_VLEN  = 10'(VLINES);
   localparam logic [9:0] C_HA0   = 10'(HACT_START);
   localparam logic [9:0] C_HA1   = 10'(HACT_START + HACT);
   localparam logic [9:0] C_VA0   = 10'(VACT_START);
   localparam logic [9:0] C_VA1   = 10'(VACT_START + VACT);

   typedef enum logic [1:0] {SEARCH, ACQUIRE, LOCKED} state_t;

   state_t      r_state;
   state_t      w_state_nxt;
   logic        r_hs, r_vs, r_hs_d, r_vs_d;
   logic [11:0] r_rgb1, r_rgb2;
   logic [9:0]  r_hc, r_vc;
   logic        r_px_valid, r_frame_start, r_locked, r_sync_err;
   logic [9:0]  r_x, r_y;
   logic [11:0] r_rgb_o;

   logic        w_hfall, w_vfall, w_boundary, w_viol;
   logic        w_err, w_frame_good, w_pix_ok;

   assign w_hfall    = r_hs_d & ~r_hs;
   assign w_vfall    = r_vs_d & ~r_vs;
   assign w_boundary = w_hfall & w_vfall;

   // hc/vc still describe the previous sample here, so a correct line ends on HPIXELS-1
   assign w_viol = (w_hfall && (r_hc != C_HLAST)) ||
                   (r_hc == C_HLEN) ||
                   (w_vfall && !w_hfall) ||
                   (w_boundary && (r_vc != C_VLAST)) ||
                   (r_vc == C_VLEN);

   always_ff @(posedge dclk) begin
      if (clr) r_state <= SEARCH;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt  = r_state;
      w_err        = 1'b0;
      w_frame_good = 1'b0;
      case (r_state)
         SEARCH: begin
            if (w_boundary) w_state_nxt = ACQUIRE;
         end
         ACQUIRE: begin
            if (w_viol) begin
               w_err       = 1'b1;
               w_state_nxt = SEARCH;
            end else if (w_boundary) begin
               w_state_nxt = LOCKED;
            end
         end
         LOCKED: begin
            if (w_viol) begin
               w_err       = 1'b1;
               w_state_nxt = SEARCH;
            end else if (w_boundary) begin
               w_frame_good = 1'b1;
            end
         end
         default: w_state_nxt = SEARCH;
      endcase
   end

   // r_state, hc, vc and r_rgb2 all describe the same sample, keeping x/y aligned with RGB
   assign w_pix_ok = (r_state == LOCKED) &&
                     (r_hc >= C_HA0) && (r_hc < C_HA1) &&
                     (r_vc >= C_VA0) && (r_vc < C_VA1);

   always_ff @(posedge dclk) begin
      if (clr) begin
         r_hs          <= 1'b1;
         r_vs          <= 1'b1;
         r_hs_d        <= 1'b1;
         r_vs_d        <= 1'b1;
         r_rgb1        <= '0;
         r_rgb2        <= '0;
         r_hc          <= '0;
         r_vc          <= '0;
         r_px_valid    <= 1'b0;
         r_x           <= '0;
         r_y           <= '0;
         r_rgb_o       <= '0;
         r_frame_start <= 1'b0;
         r_locked      <= 1'b0;
         r_sync_err    <= 1'b0;
      end else begin
         r_hs   <= hsync;
         r_vs   <= vsync;
         r_hs_d <= r_hs;
         r_vs_d <= r_vs;
         r_rgb1 <= {red_i, green_i, blue_i};
         r_rgb2 <= r_rgb1;

         if (w_hfall)          r_hc <= '0;
         else if (r_hc != '1)  r_hc <= r_hc + 10'd1;

         if (w_hfall) begin
            if (w_vfall)          r_vc <= '0;
            else if (r_vc != '1)  r_vc <= r_vc + 10'd1;
         end

         r_sync_err    <= w_err;
         r_frame_start <= w_frame_good;
         r_locked      <= (w_state_nxt == LOCKED);
         r_px_valid    <= w_pix_ok;
         r_x           <= w_pix_ok ? (r_hc - C_HA0) : '0;
         r_y           <= w_pix_ok ? (r_vc - C_VA0) : '0;
         r_rgb_o       <= w_pix_ok ? r_rgb2 : '0;
      end
   end

   assign px_valid    = r_px_valid;
   assign x           = r_x;
   assign y           = r_y;
   assign red_o       = r_rgb_o[11:8];
   assign green_o     = r_rgb_o[7:4];
   assign blue_o      = r_rgb_o[3:0];
   assign frame_start = r_frame_start;
   assign locked      = r_locked;
   assign sync_err    = r_sync_err;

endmodule

// File: tb/tb_vga_capture.sv
// Directed bench for vga_capture on a reduced 32x10 raster (20x6 active) so whole frames stay short.
module tb_vga_capture;

   localparam int HP  = 32;
   localparam int VL  = 10;
   localparam int HA0 = 6;
   localparam int HA  = 20;
   localparam int VA0 = 2;
   localparam int VA  = 6;
   localparam int HSW = 4;
   localparam int VSW = 2;

   logic       dclk;
   logic       clr;
   logic       hsync, vsync;
   logic [3:0] red_i, green_i, blue_i;
   logic       px_valid;
   logic [9:0] x, y;
   logic [3:0] red_o, green_o, blue_o;
   logic       frame_start, locked, sync_err;

   int n_cmp  = 0;
   int n_fail = 0;

   int         n_valid = 0;
   int         n_fs    = 0;
   int         n_err   = 0;
   int         n_bad   = 0;
   logic [9:0] last_x  = '0;
   logic [9:0] last_y  = '0;
   bit         mon_en  = 1'b0;

   vga_capture #(
      .HPIXELS(HP), .VLINES(VL), .HACT_START(HA0), .HACT(HA), .VACT_START(VA0), .VACT(VA)
   ) dut (
      .dclk(dclk), .clr(clr), .hsync(hsync), .vsync(vsync),
      .red_i(red_i), .green_i(green_i), .blue_i(blue_i),
      .px_valid(px_valid), .x(x), .y(y),
      .red_o(red_o), .green_o(green_o), .blue_o(blue_o),
      .frame_start(frame_start), .locked(locked), .sync_err(sync_err)
   );

   initial dclk = 1'b0;
   always #5 dclk = ~dclk;

   // Stimulus colour is {x, y, A}, so every valid output must carry its own coordinates
   always @(negedge dclk) begin
      if (mon_en) begin
         if (px_valid === 1'b1) begin
            n_valid <= n_valid + 1;
            last_x  <= x;
            last_y  <= y;
            if ({red_o, green_o, blue_o} !== {x[3:0], y[3:0], 4'hA}) n_bad <= n_bad + 1;
         end else if ({x, y, red_o, green_o, blue_o} !== 32'd0) begin
            n_bad <= n_bad + 1;
         end
         if (frame_start === 1'b1) n_fs  <= n_fs + 1;
         if (sync_err === 1'b1)    n_err <= n_err + 1;
      end
   end

   function automatic logic [11:0] rgb_of(int h, int v);
      if (h >= HA0 && h < HA0 + HA && v >= VA0 && v < VA0 + VA)
         return {4'(h - HA0), 4'(v - VA0), 4'hA};
      return 12'h000;
   endfunction

   task automatic cyc(logic hs, logic vs, logic [11:0] rgb);
      hsync = hs;
      vsync = vs;
      {red_i, green_i, blue_i} = rgb;
      @(posedge dclk);
      #1;
   endtask

   task automatic pix(int h, int v);
      cyc(h >= HSW, v >= VSW, rgb_of(h, v));
   endtask

   task automatic run_lines(int v0, int v1);
      for (int v = v0; v <= v1; v++)
         for (int h = 0; h < HP; h++) pix(h, v);
   endtask

   task automatic run_frame();
      run_lines(0, VL - 1);
   endtask

   task automatic test_reset();
      int s_err;
      clr    = 1'b1;
      mon_en = 1'b0;
      pix(0, 5);
      if ({px_valid, x, y, red_o, green_o, blue_o, frame_start, locked, sync_err} !== 36'd0) begin
         $display("FAIL reset_outputs: got %b want all zero",
                  {px_valid, x, y, red_o, green_o, blue_o, frame_start, locked, sync_err});
         n_fail++;
      end
      n_cmp++;
      mon_en = 1'b1;
      pix(1, 5);
      pix(2, 5);
      clr   = 1'b0;
      s_err = n_err;
      for (int h = 3; h < 10; h++) pix(h, 5);
      if (n_err - s_err !== 0) begin
         $display("FAIL reset_release_err: got %0d sync_err pulses want 0", n_err - s_err);
         n_fail++;
      end
      n_cmp++;
      if (locked !== 1'b0) begin
         $display("FAIL reset_locked: got %0b want 0", locked);
         n_fail++;
      end
      n_cmp++;
   endtask

   task automatic test_lock();
      int s_valid, s_fs, s_err, s_bad;
      for (int h = 10; h < HP; h++) pix(h, 5);
      run_lines(6, VL - 1);
      run_frame();
      if (locked !== 1'b0) begin
         $display("FAIL acquire_not_locked: got %0b want 0", locked);
         n_fail++;
      end
      n_cmp++;
      for (int v = 0; v < VL; v++) begin
         for (int h = 0; h < HP; h++) begin
            pix(h, v);
            if (v == 0 && h == 0) begin
               if (locked !== 1'b0) begin
                  $display("FAIL lock_edge_early: got %0b want 0", locked);
                  n_fail++;
               end
               n_cmp++;
            end
            if (v == 0 && h == 1) begin
               if (locked !== 1'b1) begin
                  $display("FAIL lock_rise: got %0b want 1", locked);
                  n_fail++;
               end
               n_cmp++;
            end
            if (v == 2 && h == 7) begin
               if (px_valid !== 1'b0) begin
                  $display("FAIL first_valid_early: got %0b want 0", px_valid);
                  n_fail++;
               end
               n_cmp++;
            end
            if (v == 2 && h == 8) begin
               if ({px_valid, x, y, red_o, green_o, blue_o} !== {1'b1, 10'd0, 10'd0, 12'h00A}) begin
                  $display("FAIL first_pixel: got v=%0b x=%0d y=%0d rgb=%h want v=1 x=0 y=0 rgb=00a",
                           px_valid, x, y, {red_o, green_o, blue_o});
                  n_fail++;
               end
               n_cmp++;
            end
            if (v == 4 && h == 20) begin
               if ({px_valid, x, y, red_o, green_o, blue_o} !== {1'b1, 10'd12, 10'd2, 12'hC2A}) begin
                  $display("FAIL mid_pixel: got v=%0b x=%0d y=%0d rgb=%h want v=1 x=12 y=2 rgb=c2a",
                           px_valid, x, y, {red_o, green_o, blue_o});
                  n_fail++;
               end
               n_cmp++;
            end
         end
      end
      s_err = n_err;
      s_bad = n_bad;
      for (int f = 0; f < 2; f++) begin
         s_valid = n_valid;
         s_fs    = n_fs;
         run_frame();
         if (n_valid - s_valid !== HA * VA) begin
            $display("FAIL frame_valid_count: got %0d want %0d", n_valid - s_valid, HA * VA);
            n_fail++;
         end
         n_cmp++;
         if (n_fs - s_fs !== 1) begin
            $display("FAIL frame_start_count: got %0d want 1", n_fs - s_fs);
            n_fail++;
         end
         n_cmp++;
      end
      if ({last_x, last_y} !== {10'd19, 10'd5}) begin
         $display("FAIL last_pixel: got x=%0d y=%0d want x=19 y=5", last_x, last_y);
         n_fail++;
      end
      n_cmp++;
      if (n_err - s_err !== 0 || n_bad - s_bad !== 0) begin
         $display("FAIL nominal_clean: got err=%0d bad=%0d want 0/0", n_err - s_err, n_bad - s_bad);
         n_fail++;
      end
      n_cmp++;
   endtask

   task automatic test_short_line();
      int s_valid;
      run_lines(0, 3);
      for (int h = 0; h < HP - 1; h++) pix(h, 4);
      pix(0, 5);
      if (sync_err !== 1'b0) begin
         $display("FAIL short_line_err_early: got %0b want 0", sync_err);
         n_fail++;
      end
      n_cmp++;
      pix(1, 5);
      if ({sync_err, locked, px_valid} !== 3'b100) begin
         $display("FAIL short_line_err: got err/locked/valid=%b want 100", {sync_err, locked, px_valid});
         n_fail++;
      end
      n_cmp++;
      pix(2, 5);
      if (sync_err !== 1'b0) begin
         $display("FAIL short_line_err_width: got %0b want 0", sync_err);
         n_fail++;
      end
      n_cmp++;
      s_valid = n_valid;
      for (int h = 3; h < HP; h++) pix(h, 5);
      run_lines(6, VL - 1);
      run_frame();
      if (n_valid - s_valid !== 0) begin
         $display("FAIL short_line_no_valid: got %0d valid cycles want 0", n_valid - s_valid);
         n_fail++;
      end
      n_cmp++;
      pix(0, 0);
      pix(1, 0);
      if (locked !== 1'b1) begin
         $display("FAIL short_line_relock: got %0b want 1", locked);
         n_fail++;
      end
      n_cmp++;
      for (int h = 2; h < HP; h++) pix(h, 0);
      run_lines(1, VL - 1);
   endtask

   task automatic test_hold_hsync();
      int s_valid, s_err;
      run_lines(0, 3);
      s_err = n_err;
      for (int k = 0; k < 1100; k++) begin
         cyc(1'b1, 1'b1, 12'h000);
         if (k == 1) begin
            if (sync_err !== 1'b0) begin
               $display("FAIL hold_err_early: got %0b want 0", sync_err);
               n_fail++;
            end
            n_cmp++;
         end
         if (k == 2) begin
            if ({sync_err, locked} !== 2'b10) begin
               $display("FAIL hold_err: got err/locked=%b want 10", {sync_err, locked});
               n_fail++;
            end
            n_cmp++;
            s_valid = n_valid;
         end
      end
      run_lines(5, VL - 1);
      run_frame();
      if (n_valid - s_valid !== 0 || n_err - s_err !== 1) begin
         $display("FAIL hold_quiet: got valid=%0d err=%0d want 0/1", n_valid - s_valid, n_err - s_err);
         n_fail++;
      end
      n_cmp++;
      run_frame();
   endtask

   task automatic test_vfall_mid();
      int s_valid;
      run_lines(0, 3);
      for (int h = 0; h < HP; h++) begin
         cyc(h >= HSW, h < 16, rgb_of(h, 4));
         if (h == 16) begin
            if (sync_err !== 1'b0) begin
               $display("FAIL vfall_err_early: got %0b want 0", sync_err);
               n_fail++;
            end
            n_cmp++;
         end
         if (h == 17) begin
            if ({sync_err, locked} !== 2'b10) begin
               $display("FAIL vfall_err: got err/locked=%b want 10", {sync_err, locked});
               n_fail++;
            end
            n_cmp++;
         end
         if (h == 18) s_valid = n_valid;
      end
      run_lines(5, VL - 1);
      if (n_valid - s_valid !== 0) begin
         $display("FAIL vfall_no_valid: got %0d valid cycles want 0", n_valid - s_valid);
         n_fail++;
      end
      n_cmp++;
      run_frame();
      run_frame();
   endtask

   task automatic test_short_frame();
      run_lines(0, VL - 2);
      pix(0, 0);
      pix(1, 0);
      if ({sync_err, frame_start, locked} !== 3'b100) begin
         $display("FAIL short_frame: got err/fs/locked=%b want 100", {sync_err, frame_start, locked});
         n_fail++;
      end
      n_cmp++;
      for (int h = 2; h < HP; h++) pix(h, 0);
      run_lines(1, VL - 1);
      run_frame();
      run_frame();
   endtask

   task automatic test_coincident();
      run_lines(0, VL - 2);
      for (int h = 0; h < HP - 1; h++) pix(h, VL - 1);
      pix(0, 0);
      pix(1, 0);
      if ({sync_err, frame_start, locked} !== 3'b100) begin
         $display("FAIL coincident_err: got err/fs/locked=%b want 100", {sync_err, frame_start, locked});
         n_fail++;
      end
      n_cmp++;
      for (int h = 2; h < HP; h++) pix(h, 0);
      run_lines(1, VL - 1);
      pix(0, 0);
      pix(1, 0);
      if (locked !== 1'b0) begin
         $display("FAIL coincident_search: got locked=%0b want 0", locked);
         n_fail++;
      end
      n_cmp++;
      for (int h = 2; h < HP; h++) pix(h, 0);
      run_lines(1, VL - 1);
      run_frame();
   endtask

   task automatic test_reset_mid();
      int s_err;
      run_lines(0, 2);
      for (int h = 0; h < 10; h++) pix(h, 3);
      if ({px_valid, x, y, red_o, green_o, blue_o} !== {1'b1, 10'd1, 10'd1, 12'h11A}) begin
         $display("FAIL pre_reset_pixel: got v=%0b x=%0d y=%0d rgb=%h want v=1 x=1 y=1 rgb=11a",
                  px_valid, x, y, {red_o, green_o, blue_o});
         n_fail++;
      end
      n_cmp++;
      clr = 1'b1;
      pix(10, 3);
      if ({px_valid, x, y, red_o, green_o, blue_o, frame_start, locked, sync_err} !== 36'd0) begin
         $display("FAIL mid_reset_outputs: got %b want all zero",
                  {px_valid, x, y, red_o, green_o, blue_o, frame_start, locked, sync_err});
         n_fail++;
      end
      n_cmp++;
      pix(11, 3);
      pix(12, 3);
      clr   = 1'b0;
      s_err = n_err;
      for (int h = 13; h < HP; h++) pix(h, 3);
      run_lines(4, VL - 1);
      run_frame();
      if ({locked, 32'(n_err - s_err)} !== 33'd0) begin
         $display("FAIL mid_reset_release: got locked=%0b err=%0d want 0/0", locked, n_err - s_err);
         n_fail++;
      end
      n_cmp++;
   endtask

   task automatic test_integrity();
      if (n_bad !== 0) begin
         $display("FAIL pixel_integrity: got %0d inconsistent output cycles want 0", n_bad);
         n_fail++;
      end
      n_cmp++;
   endtask

   initial begin
      clr   = 1'b1;
      hsync = 1'b1;
      vsync = 1'b1;
      red_i = '0;
      green_i = '0;
      blue_i = '0;
      test_reset();
      test_lock();
      test_short_line();
      test_hold_hsync();
      test_vfall_mid();
      test_short_frame();
      test_coincident();
      test_reset_mid();
      test_integrity();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
